cmp_query_ctrl: RTL and testbench
=================================

Name: cmp_query_ctrl

Overview:
Initiator-side sequencer for the signed compare unit. It accepts an operand pair over a valid/ready request channel and drives the compare unit's operand, function and enable inputs. It issues EQ, then GT, then (optionally) LT queries, decodes each registered CMP_OUT/CMP_Flag response, and returns a one-hot relation (eq/gt/lt) or an error on a valid/ready result channel. It sits between the ALU control path and the compare unit.

Parameters:
DATA_WIDTH, 16, operand width; must match the compare unit input width.
TIMEOUT, 4, maximum WAIT cycles without CMP_FLAG=1 before an error is declared (range 1..255).
CHECK_LT, 0, 1 = confirm "less than" with an explicit LT query instead of deducing it.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
REQ_VALID  in  1  request operands valid
REQ_READY  out  1  controller idle; a request is accepted when REQ_VALID && REQ_READY
REQ_A  in  DATA_WIDTH  signed operand A
REQ_B  in  DATA_WIDTH  signed operand B
CMP_A  out  DATA_WIDTH  operand A to the compare unit (registered at acceptance)
CMP_B  out  DATA_WIDTH  operand B to the compare unit (registered at acceptance)
CMP_FUN  out  2  query code: 01=EQ, 10=GT, 11=LT (00 is never driven while enabled)
CMP_EN  out  1  compare enable
CMP_OUT  in  2  compare result code
CMP_FLAG  in  1  compare result valid
RES_VALID  out  1  result available
RES_READY  in  1  result consumed when RES_VALID && RES_READY
RES_EQ / RES_GT / RES_LT  out  1 each  decoded relation, one-hot when RES_ERR=0
RES_ERR  out  1  protocol error; when set, RES_EQ, RES_GT and RES_LT are all 0

Behaviour:
- Reset (asynchronous, any state): state=IDLE, REQ_READY=1, CMP_EN=0, CMP_FUN=00, CMP_A=CMP_B=0, all RES_* outputs=0, timeout counter=0.
- All outputs are registered. REQ_READY=1 only in IDLE.
- States:
  - IDLE: on request accept, latch REQ_A/REQ_B into CMP_A/CMP_B, set CMP_FUN=01, go to ISSUE.
  - ISSUE (1 cycle): CMP_EN=1 and CMP_FUN is stable. CMP_OUT/CMP_FLAG are not sampled here, because they may still hold the previous query's result. Go to WAIT.
  - WAIT: CMP_EN=1 and CMP_FUN is held. Sample CMP_FLAG each cycle.
    - CMP_FLAG=0: increment the counter. When the counter reaches TIMEOUT, go to RESP with RES_ERR=1.
    - CMP_FLAG=1: decode per query:
      - EQ query: CMP_OUT=01 gives eq, done. CMP_OUT=00 issues GT next (CMP_FUN=10, ISSUE).
      - GT query: CMP_OUT=10 gives gt, done. CMP_OUT=00 gives lt if CHECK_LT=0; if CHECK_LT=1, issue LT next (CMP_FUN=11, ISSUE).
      - LT query: CMP_OUT=11 gives lt, done. CMP_OUT=00 gives RES_ERR, because no relation holds.
      - Any other code, i.e. one not matching the active query or 00, gives RES_ERR.
    - On leaving WAIT, clear the counter.
  - RESP: CMP_EN=0, CMP_FUN=00. RES_VALID=1 and the RES_* outputs are held stable until RES_READY=1. On that edge, clear RES_*, set REQ_READY=1, go to IDLE.
- Latency, with the 1-cycle compare unit: RES_VALID rises 2*Q+1 edges after the accept edge, where Q = number of queries issued (1 for eq, 2 for gt or deduced lt, 3 for checked lt).
- RES_READY held high already in RESP: the result is consumed in its first RESP cycle. A new request can be accepted no sooner than the following cycle.
- REQ_VALID outside IDLE is ignored. Operands are never re-sampled mid-operation.
- Reset mid-operation aborts the query. No partial result is ever presented.

Test Plan:
- A=5, B=5 → one query (FUN=01). RES_EQ=1, RES_VALID 3 edges after accept.
- A=7, B=-3 → queries 01 then 10. RES_GT=1, RES_VALID 5 edges after accept. CMP_FUN must never be 00 while CMP_EN=1.
- A=-32768, B=32767, with CHECK_LT=0 and again with CHECK_LT=1 → RES_LT=1 after 2 and 3 queries respectively (RES_VALID 5 and 7 edges after accept).
- Compare model holds CMP_FLAG=0 → RES_ERR=1 after TIMEOUT=4 WAIT cycles. Model returns 10 to an EQ query → RES_ERR=1, no further queries.
- RES_READY held low for 6 cycles → RES_* stable and REQ_READY=0 throughout. A REQ_VALID pulse during this window is not accepted.
- RST low during the second WAIT → all outputs return to reset values immediately. The next request completes normally.

Source files
------------

// File: rtl/cmp_query_ctrl_if.sv
// Signal bundle around the compare-query sequencer: request, compare-unit and result channels.
// master is the sequencer's view; slave is the view of whatever surrounds it.
interface cmp_query_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic [DATA_WIDTH-1:0] REQ_A;
  logic [DATA_WIDTH-1:0] REQ_B;

  logic [DATA_WIDTH-1:0] CMP_A;
  logic [DATA_WIDTH-1:0] CMP_B;
  logic [1:0]            CMP_FUN;
  logic                  CMP_EN;
  logic [1:0]            CMP_OUT;
  logic                  CMP_FLAG;

  logic                  RES_VALID;
  logic                  RES_READY;
  logic                  RES_EQ;
  logic                  RES_GT;
  logic                  RES_LT;
  logic                  RES_ERR;

  modport master (
    input  REQ_VALID, REQ_A, REQ_B, CMP_OUT, CMP_FLAG, RES_READY,
    output REQ_READY, CMP_A, CMP_B, CMP_FUN, CMP_EN,
           RES_VALID, RES_EQ, RES_GT, RES_LT, RES_ERR
  );

  modport slave (
    output REQ_VALID, REQ_A, REQ_B, CMP_OUT, CMP_FLAG, RES_READY,
    input  REQ_READY, CMP_A, CMP_B, CMP_FUN, CMP_EN,
           RES_VALID, RES_EQ, RES_GT, RES_LT, RES_ERR
  );
endinterface

// File: rtl/cmp_query_ctrl.sv
// Sequences EQ, GT and optionally LT queries to the signed compare unit and returns
// a one-hot relation (or an error) for each accepted operand pair. All outputs are registered.
module cmp_query_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 4,
  parameter int CHECK_LT   = 0
) (
  input logic              CLK,
  input logic              RST,
  cmp_query_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic err;
    logic lt;
    logic gt;
    logic eq;
  } res_t;

  // Query codes double as the matching "relation holds" response codes.
  localparam logic [1:0] FUN_NONE = 2'b00;
  localparam logic [1:0] FUN_EQ   = 2'b01;
  localparam logic [1:0] FUN_GT   = 2'b10;
  localparam logic [1:0] FUN_LT   = 2'b11;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                state,     state_n;
  logic [DATA_WIDTH-1:0] cmp_a,     cmp_a_n;
  logic [DATA_WIDTH-1:0] cmp_b,     cmp_b_n;
  logic [1:0]            cmp_fun,   cmp_fun_n;
  logic                  cmp_en,    cmp_en_n;
  logic                  req_ready, req_ready_n;
  logic                  res_valid, res_valid_n;
  res_t                  res,       res_n;
  logic [7:0]            cnt,       cnt_n;
  logic [7:0]            cnt_inc;

  logic                  finish;
  res_t                  res_fin;

  assign cnt_inc = cnt + 8'd1;

  // NOTE: every target gets its default first, so no path through the case can infer a latch.
  always_comb begin
    state_n     = state;
    cmp_a_n     = cmp_a;
    cmp_b_n     = cmp_b;
    cmp_fun_n   = cmp_fun;
    cmp_en_n    = cmp_en;
    req_ready_n = req_ready;
    res_valid_n = res_valid;
    res_n       = res;
    cnt_n       = cnt;
    finish      = 1'b0;
    res_fin     = '0;

    unique case (state)
      S_IDLE: begin
        if (bus.REQ_VALID) begin
          cmp_a_n     = bus.REQ_A;
          cmp_b_n     = bus.REQ_B;
          cmp_fun_n   = FUN_EQ;
          cmp_en_n    = 1'b1;
          req_ready_n = 1'b0;
          state_n     = S_ISSUE;
        end
      end

      // The compare outputs may still reflect the previous query here; ignore them.
      S_ISSUE: state_n = S_WAIT;

      S_WAIT: begin
        if (!bus.CMP_FLAG) begin
          if (cnt_inc == TIMEOUT_CNT) begin
            finish      = 1'b1;
            res_fin.err = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end else begin
          cnt_n = '0;
          if (bus.CMP_OUT == cmp_fun) begin
            finish = 1'b1;
            case (cmp_fun)
              FUN_EQ:  res_fin.eq  = 1'b1;
              FUN_GT:  res_fin.gt  = 1'b1;
              FUN_LT:  res_fin.lt  = 1'b1;
              default: res_fin.err = 1'b1;
            endcase
          end else if (bus.CMP_OUT == FUN_NONE) begin
            case (cmp_fun)
              FUN_EQ: begin
                cmp_fun_n = FUN_GT;
                state_n   = S_ISSUE;
              end
              FUN_GT: begin
                if (CHECK_LT != 0) begin
                  cmp_fun_n = FUN_LT;
                  state_n   = S_ISSUE;
                end else begin
                  finish     = 1'b1;
                  res_fin.lt = 1'b1;
                end
              end
              // A negative LT answer after negative EQ and GT means no relation holds.
              default: begin
                finish      = 1'b1;
                res_fin.err = 1'b1;
              end
            endcase
          end else begin
            finish      = 1'b1;
            res_fin.err = 1'b1;
          end
        end
      end

      S_RESP: begin
        if (bus.RES_READY) begin
          res_valid_n = 1'b0;
          res_n       = '0;
          req_ready_n = 1'b1;
          state_n     = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase

    if (finish) begin
      state_n     = S_RESP;
      cmp_en_n    = 1'b0;
      cmp_fun_n   = FUN_NONE;
      cnt_n       = '0;
      res_valid_n = 1'b1;
      res_n       = res_fin;
    end
  end

  // NOTE: non-blocking updates make every register see pre-edge values; blocking ones here would race.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      cmp_a     <= '0;
      cmp_b     <= '0;
      cmp_fun   <= FUN_NONE;
      cmp_en    <= 1'b0;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      res       <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      cmp_a     <= cmp_a_n;
      cmp_b     <= cmp_b_n;
      cmp_fun   <= cmp_fun_n;
      cmp_en    <= cmp_en_n;
      req_ready <= req_ready_n;
      res_valid <= res_valid_n;
      res       <= res_n;
      cnt       <= cnt_n;
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.CMP_A     = cmp_a;
  assign bus.CMP_B     = cmp_b;
  assign bus.CMP_FUN   = cmp_fun;
  assign bus.CMP_EN    = cmp_en;
  assign bus.RES_VALID = res_valid;
  assign bus.RES_EQ    = res.eq;
  assign bus.RES_GT    = res.gt;
  assign bus.RES_LT    = res.lt;
  assign bus.RES_ERR   = res.err;

endmodule

// File: tb/tb_cmp_query_ctrl.sv
// Bench for cmp_query_ctrl: two instances (deduced and checked LT) each driven by a behavioural
// compare unit, with directed and random transactions checked against a relation-level model.
module tb_cmp_query_ctrl;

  localparam int DW = 16;
  localparam int TO = 4;

  localparam int M_NORM  = 0;  // answers correctly, after 'extra' idle cycles per query
  localparam int M_STUCK = 1;  // never raises CMP_FLAG
  localparam int M_WRONG = 2;  // always answers 10

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic          req_valid [2];
  logic [DW-1:0] req_a     [2];
  logic [DW-1:0] req_b     [2];
  logic          res_ready [2];
  int            mode      [2];
  int            extra     [2];

  logic          req_ready [2];
  logic [DW-1:0] cmp_a     [2];
  logic [DW-1:0] cmp_b     [2];
  logic [1:0]    cmp_fun   [2];
  logic          cmp_en    [2];
  logic          res_valid [2];
  logic [3:0]    res_v     [2];  // {err, lt, gt, eq}
  int            qcnt      [2];
  int            badf      [2];

  cmp_query_ctrl_if #(.DATA_WIDTH(DW)) cif [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cmp_query_ctrl #(
      .DATA_WIDTH(DW),
      .TIMEOUT   (TO),
      .CHECK_LT  (g)
    ) u_dut (
      .CLK(CLK),
      .RST(RST),
      .bus(cif[g])
    );

    assign cif[g].REQ_VALID = req_valid[g];
    assign cif[g].REQ_A     = req_a[g];
    assign cif[g].REQ_B     = req_b[g];
    assign cif[g].RES_READY = res_ready[g];

    assign req_ready[g] = cif[g].REQ_READY;
    assign cmp_a[g]     = cif[g].CMP_A;
    assign cmp_b[g]     = cif[g].CMP_B;
    assign cmp_fun[g]   = cif[g].CMP_FUN;
    assign cmp_en[g]    = cif[g].CMP_EN;
    assign res_valid[g] = cif[g].RES_VALID;
    assign res_v[g]     = {cif[g].RES_ERR, cif[g].RES_LT, cif[g].RES_GT, cif[g].RES_EQ};

    // Behavioural compare unit: registered result one edge after it sees an enabled query.
    logic       flag_q   = 1'b0;
    logic [1:0] out_q    = 2'b00;
    int         age      = 0;
    int         age_n;
    logic       last_en  = 1'b0;
    logic [1:0] last_fun = 2'b00;

    assign cif[g].CMP_FLAG = flag_q;
    assign cif[g].CMP_OUT  = out_q;

    always @(posedge CLK) begin
      if (cif[g].CMP_EN) begin
        age_n = (last_en && cif[g].CMP_FUN == last_fun) ? age + 1 : 0;
        if (mode[g] == M_STUCK) begin
          flag_q <= 1'b0;
        end else if (mode[g] == M_WRONG) begin
          flag_q <= 1'b1;
          out_q  <= 2'b10;
        end else if (age_n >= extra[g]) begin
          flag_q <= 1'b1;
          case (cif[g].CMP_FUN)
            2'b01:   out_q <= (cif[g].CMP_A == cif[g].CMP_B) ? 2'b01 : 2'b00;
            2'b10:   out_q <= ($signed(cif[g].CMP_A) > $signed(cif[g].CMP_B)) ? 2'b10 : 2'b00;
            2'b11:   out_q <= ($signed(cif[g].CMP_A) < $signed(cif[g].CMP_B)) ? 2'b11 : 2'b00;
            default: out_q <= 2'b00;
          endcase
        end else begin
          flag_q <= 1'b0;
        end
      end else begin
        age_n = 0;
        flag_q <= 1'b0;
      end
      age      <= age_n;
      last_en  <= cif[g].CMP_EN;
      last_fun <= cif[g].CMP_FUN;
    end

    // Counts queries issued (each new enabled function code) and illegal 00 codes while enabled.
    int         q_mon    = 0;
    int         bad_mon  = 0;
    logic       prev_en  = 1'b0;
    logic [1:0] prev_fun = 2'b00;

    always @(negedge CLK) begin
      if (cif[g].CMP_EN && (!prev_en || cif[g].CMP_FUN != prev_fun)) q_mon <= q_mon + 1;
      if (cif[g].CMP_EN && cif[g].CMP_FUN == 2'b00) bad_mon <= bad_mon + 1;
      prev_en  <= cif[g].CMP_EN;
      prev_fun <= cif[g].CMP_FUN;
    end

    assign qcnt[g] = q_mon;
    assign badf[g] = bad_mon;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Relation-level reference: expected {err,lt,gt,eq}, number of queries, and the number of
  // rising edges from the accept edge (counted as 1) to the edge after which RES_VALID is high.
  task automatic ref_model(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                           input int check_lt, input int md, input int ex,
                           output logic [3:0] ev, output int q, output int lat);
    if (md == M_STUCK) begin
      ev = 4'b1000; q = 1; lat = TO + 2;
    end else if (md == M_WRONG) begin
      ev = 4'b1000; q = 1; lat = 3;
    end else begin
      if (a == b)     begin ev = 4'b0001; q = 1; end
      else if (a > b) begin ev = 4'b0010; q = 2; end
      else            begin ev = 4'b0100; q = (check_lt != 0) ? 3 : 2; end
      lat = q * (2 + ex) + 1;
    end
  endtask

  task automatic run_txn(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int md, input int ex, input int hold);
    logic [3:0] ev;
    int         eq_n, elat, lat, q0, b0;
    bit         got;

    ref_model(a, b, i, md, ex, ev, eq_n, elat);
    mode[i]      = md;
    extra[i]     = ex;
    res_ready[i] = (hold == 0);
    q0 = qcnt[i];
    b0 = badf[i];

    @(negedge CLK);
    req_a[i]     = a;
    req_b[i]     = b;
    req_valid[i] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (req_ready[i]) got = 1'b1;
      else @(negedge CLK);
    end
    check("accept_ready", 32'(got), 32'd1);
    if (!got) begin
      req_valid[i] = 1'b0;
      return;
    end

    @(posedge CLK);
    #1;
    req_valid[i] = 1'b0;
    req_a[i]     = DW'($urandom);
    req_b[i]     = DW'($urandom);

    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        check("latched_operands", {cmp_a[i], cmp_b[i]}, {a, b});
        check("first_query_eq", {29'd0, cmp_en[i], cmp_fun[i]}, 32'b101);
      end
      if (res_valid[i]) got = 1'b1;
      else begin
        @(posedge CLK);
        lat++;
      end
    end
    check("res_valid_seen", 32'(got), 32'd1);
    check("latency", lat, elat);
    check("relation", 32'(res_v[i]), 32'(ev));
    check("resp_cmp_idle", {29'd0, cmp_en[i], cmp_fun[i]}, 32'd0);
    check("queries", qcnt[i] - q0, eq_n);
    check("fun_00_while_en", badf[i] - b0, 0);

    for (int h = 0; h < hold; h++) begin
      if (h == 2) begin
        req_valid[i] = 1'b1;
        req_a[i]     = ~a;
        req_b[i]     = ~b;
      end else begin
        req_valid[i] = 1'b0;
      end
      @(posedge CLK);
      @(negedge CLK);
      check("hold_result", {27'd0, res_valid[i], res_v[i]}, {27'd0, 1'b1, ev});
      check("hold_not_ready", 32'(req_ready[i]), 32'd0);
    end
    req_valid[i] = 1'b0;
    res_ready[i] = 1'b1;

    @(posedge CLK);
    @(negedge CLK);
    check("released", {26'd0, req_ready[i], cmp_en[i], res_valid[i], res_v[i]}, {26'd0, 1'b1, 1'b0, 1'b0, 4'b0});
    check("operands_kept", {cmp_a[i], cmp_b[i]}, {a, b});
  endtask

  task automatic reset_test();
    bit seen;
    mode[0]      = M_NORM;
    extra[0]     = 0;
    res_ready[0] = 1'b1;
    @(negedge CLK);
    req_a[0]     = 16'sd7;
    req_b[0]     = -16'sd3;
    req_valid[0] = 1'b1;
    @(posedge CLK);
    #1;
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      if (cmp_en[0] && cmp_fun[0] == 2'b10) seen = 1'b1;
    end
    check("rst_reach_gt_query", 32'(seen), 32'd1);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("rst_async_outputs", {23'd0, req_ready[0], cmp_en[0], cmp_fun[0], res_valid[0], res_v[0]},
          {23'd0, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0});
    check("rst_async_operands", {cmp_a[0], cmp_b[0]}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    run_txn(0, 16'sd7, -16'sd3, M_NORM, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] corner [4];
    logic [DW-1:0] ra, rb;
    int            ri, rmd, rex, rhold;

    corner[0] = 16'h8000;
    corner[1] = 16'h7FFF;
    corner[2] = 16'h0000;
    corner[3] = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_a[i]     = '0;
      req_b[i]     = '0;
      res_ready[i] = 1'b1;
      mode[i]      = M_NORM;
      extra[i]     = 0;
    end

    #12;
    for (int i = 0; i < 2; i++) begin
      check("reset_state", {23'd0, req_ready[i], cmp_en[i], cmp_fun[i], res_valid[i], res_v[i]},
            {23'd0, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0});
      check("reset_operands", {cmp_a[i], cmp_b[i]}, 32'd0);
    end
    @(negedge CLK);
    RST = 1'b1;

    run_txn(0, 16'sd5, 16'sd5, M_NORM, 0, 0);
    run_txn(0, 16'sd7, -16'sd3, M_NORM, 0, 0);
    run_txn(0, 16'h8000, 16'h7FFF, M_NORM, 0, 0);
    run_txn(1, 16'h8000, 16'h7FFF, M_NORM, 0, 0);
    run_txn(0, 16'sd3, 16'sd9, M_STUCK, 0, 0);
    run_txn(1, 16'sd4, 16'sd4, M_WRONG, 0, 0);
    run_txn(0, 16'sd11, 16'sd2, M_NORM, 0, 6);
    run_txn(1, -16'sd5, -16'sd5, M_NORM, TO - 1, 0);
    run_txn(1, 16'h7FFF, 16'h8000, M_NORM, TO - 1, 0);
    reset_test();

    for (int n = 0; n < 40; n++) begin
      ri = int'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : DW'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : DW'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      rmd = int'($urandom_range(0, 19));
      rmd = (rmd == 0) ? M_STUCK : (rmd == 1) ? M_WRONG : M_NORM;
      rex = int'($urandom_range(0, TO - 1));
      rhold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_txn(ri, ra, rb, rmd, rex, rhold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
